vram_scheduler: RTL
===================

Name: vram_scheduler

Overview:
- Per-frame command scheduler for the single shared MIG user port (128-bit words, 16 bytes each).
- Streams the previous EPD state out of VRAM (readback, toward bi_fifo) and the new state back into VRAM (writeback, from bo_fifo).
- Arbitrates between read and write bursts, enforces read-FIFO flow control and reports protocol errors.
- Sits in the clk_mif domain between the FIFOs and mig_wrapper.

Parameters:
- BURST_LEN, 32, words per full burst (1..64).
- BASE_ADDR, 30'h0, byte address of the state buffer; reads and writes use the same region.
- RD_FIFO_DEPTH, 64, MIG read-FIFO depth in words.

Ports:
- clk  in  1  MIG user clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; scheduling permitted.
- vsync  in  1  single-cycle frame-start pulse.
- frame_bytes  in  24  bytes per frame; bits [3:0] are ignored.
- pix_read  out  128  readback data.
- pix_read_valid  out  1
- pix_read_ready  in  1
- pix_write  in  128  writeback data.
- pix_write_valid  in  1
- pix_write_ready  out  1
- mig_cmd_en  out  1
- mig_cmd_instr  out  3  3'b001 = read, 3'b000 = write.
- mig_cmd_bl  out  6  words minus 1.
- mig_cmd_byte_addr  out  30
- mig_cmd_full  in  1
- mig_wr_en  out  1
- mig_wr_mask  out  16  constant 0.
- mig_wr_data  out  128
- mig_wr_full  in  1
- mig_wr_underrun  in  1
- mig_rd_en  out  1
- mig_rd_data  in  128
- mig_rd_empty  in  1
- mig_rd_overflow  in  1
- busy  out  1  frame in progress.
- error  out  1  sticky, cleared only by rst.

Behaviour:
- Reset: state IDLE; all counters 0; mig_cmd_en=0; busy=0; error=0; last_grant=WRITE, so the first grant goes to read.
- frame_words = frame_bytes[23:4], 20 bits. Counters: rd_issued, wr_issued, wr_staged and rd_outstanding (7 bits).
- Read path, combinational:
  - pix_read_valid = !mig_rd_empty; pix_read = mig_rd_data.
  - mig_rd_en = valid && ready. Each pop decrements rd_outstanding.
- Write path, combinational:
  - pix_write_ready = busy && !mig_wr_full && (wr_issued + wr_staged < frame_words).
  - mig_wr_en = pix_write_valid && pix_write_ready; mig_wr_data = pix_write. Each push increments wr_staged.
- IDLE: on vsync && enable && frame_words != 0, clear counters, set busy=1 and go to ARB. Otherwise vsync is ignored.
- ARB, eligibility:
  - rd_len = min(BURST_LEN, frame_words - rd_issued).
  - Read eligible: rd_len > 0 && rd_outstanding + rd_len <= RD_FIFO_DEPTH.
  - wr_len = min(BURST_LEN, frame_words - wr_issued).
  - Write eligible: wr_len > 0 && wr_staged >= wr_len. Writes never precede staged data.
- ARB, grant:
  - Requires !mig_cmd_full and enable.
  - If both paths are eligible, grant the one opposite last_grant (round robin).
  - If one is eligible, grant it. Then go to CMD.
- CMD, one cycle:
  - mig_cmd_en=1; instr, bl = len-1 and addr = BASE_ADDR + (issued<<4) are all registered.
  - On issue: rd_outstanding += rd_len, or wr_staged -= wr_len. issued += len. last_grant updated. Return to ARB.
  - Push/pop counter updates in the same cycle combine arithmetically.
- Exit to DRAIN: from ARB when rd_issued == wr_issued == frame_words, or when enable falls.
- DRAIN: wait until rd_outstanding == 0, then busy=0 and go to IDLE. Staged but unissued write words are discarded logically; error is set if wr_staged != 0 on an enable-drop exit.
- Error sources (error=1): vsync while busy (pulse ignored, frame continues), mig_rd_overflow, mig_wr_underrun, and rd_outstanding underflow (pop at 0).
- Reset mid-frame: immediate return to IDLE. Outstanding MIG data is the system's responsibility, since the FIFOs are reset together.

Decomposition:
- Shared package vram_pkg: MIG_CMD_RD/MIG_CMD_WR instruction constants, WORD_BYTES=16, state encoding (IDLE, ARB, CMD, DRAIN).
- No sub-module is needed. Arbitration is small enough to live inline.

Test Plan:
- Single burst:
  - Stimulus: frame_bytes=512 (32 words), BURST_LEN=32, sink always ready, writeback fed from readback.
  - Response: one read cmd (bl=31, addr=0), then one write cmd (bl=31, addr=0), then busy falls; error=0.
- Partial tail:
  - Stimulus: frame_bytes=1200 (75 words).
  - Response: reads at 0x000, 0x200, 0x400 with bl 31, 31, 10; writes identical; no extra cmd.
- Flow control:
  - Stimulus: pix_read_ready=0, frame of 256 words.
  - Response: exactly 2 read cmds issued (64 outstanding), no third until pops occur.
- Arbitration:
  - Stimulus: both paths eligible continuously.
  - Response: cmd_instr alternates R, W, R, W, with the first grant being R.
- Errors:
  - Stimulus: vsync mid-frame.
  - Response: error=1 and frame completes normally. mig_rd_overflow pulse also gives error=1; error clears only after rst.
- Enable drop:
  - Stimulus: enable=0 after the first read cmd with 32 words still in the MIG FIFO.
  - Response: no new cmds; busy stays 1 until 32 pops complete, then returns to IDLE.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared constants and encodings for the VRAM frame scheduler.
// MIG instruction codes, word size and FSM state encoding.
package vram_pkg;

  localparam logic [2:0]  MIG_CMD_RD    = 3'b001;
  localparam logic [2:0]  MIG_CMD_WR    = 3'b000;
  localparam int unsigned WORD_BYTES    = 16;
  localparam int unsigned FRAME_WORDS_W = 20;
  localparam int unsigned OUTST_W       = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    CMD   = 2'd2,
    DRAIN = 2'd3
  } sched_state_t;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

endpackage

// File: rtl/vram_scheduler.sv
// Per-frame MIG command scheduler: reads the previous EPD state out of VRAM
// and writes the new state back, round-robin arbitrating read/write bursts.
module vram_scheduler
  import vram_pkg::*;
#(
  parameter int unsigned BURST_LEN     = 32,
  parameter logic [29:0] BASE_ADDR     = 30'h0,
  parameter int unsigned RD_FIFO_DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         vsync,
  input  logic [23:0]  frame_bytes,
  output logic [127:0] pix_read,
  output logic         pix_read_valid,
  input  logic         pix_read_ready,
  input  logic [127:0] pix_write,
  input  logic         pix_write_valid,
  output logic         pix_write_ready,
  output logic         mig_cmd_en,
  output logic [2:0]   mig_cmd_instr,
  output logic [5:0]   mig_cmd_bl,
  output logic [29:0]  mig_cmd_byte_addr,
  input  logic         mig_cmd_full,
  output logic         mig_wr_en,
  output logic [15:0]  mig_wr_mask,
  output logic [127:0] mig_wr_data,
  input  logic         mig_wr_full,
  input  logic         mig_wr_underrun,
  output logic         mig_rd_en,
  input  logic [127:0] mig_rd_data,
  input  logic         mig_rd_empty,
  input  logic         mig_rd_overflow,
  output logic         busy,
  output logic         error
);

  localparam int unsigned FW_W = FRAME_WORDS_W;
  localparam logic [FW_W-1:0] BURST_W = FW_W'(BURST_LEN);
  localparam logic [FW_W:0]   DEPTH_W = (FW_W+1)'(RD_FIFO_DEPTH);

  sched_state_t        r_state;
  grant_t              r_last_grant;
  logic [FW_W-1:0]     r_frame_words;
  logic [FW_W-1:0]     r_rd_issued;
  logic [FW_W-1:0]     r_wr_issued;
  logic [FW_W-1:0]     r_wr_staged;
  logic [OUTST_W-1:0]  r_rd_outstanding;
  logic                r_busy;
  logic                r_error;
  logic                r_cmd_en;
  logic [2:0]          r_cmd_instr;
  logic [5:0]          r_cmd_bl;
  logic [29:0]         r_cmd_addr;

  logic [FW_W-1:0]     w_rd_remain;
  logic [FW_W-1:0]     w_wr_remain;
  logic [FW_W-1:0]     w_rd_len;
  logic [FW_W-1:0]     w_wr_len;
  logic                w_rd_elig;
  logic                w_wr_elig;
  logic                w_grant_rd;
  logic                w_grant_any;
  logic                w_pop;
  logic                w_push;
  logic                w_issue_rd;
  logic                w_issue_wr;
  logic [FW_W-1:0]     w_cmd_len;
  logic [OUTST_W-1:0]  w_outst_nxt;
  logic [FW_W-1:0]     w_staged_nxt;
  logic                w_underflow;
  logic                w_unused;

  assign w_unused = ^frame_bytes[3:0];

  // Burst lengths and eligibility for the two paths
  assign w_rd_remain = r_frame_words - r_rd_issued;
  assign w_wr_remain = r_frame_words - r_wr_issued;
  assign w_rd_len    = (w_rd_remain > BURST_W) ? BURST_W : w_rd_remain;
  assign w_wr_len    = (w_wr_remain > BURST_W) ? BURST_W : w_wr_remain;
  assign w_rd_elig   = (w_rd_len != '0) &&
                       (((FW_W+1)'(r_rd_outstanding) + (FW_W+1)'(w_rd_len)) <= DEPTH_W);
  assign w_wr_elig   = (w_wr_len != '0) && (r_wr_staged >= w_wr_len);
  assign w_grant_rd  = w_rd_elig && (!w_wr_elig || (r_last_grant == GRANT_WR));
  assign w_grant_any = w_rd_elig || w_wr_elig;

  assign pix_read        = mig_rd_data;
  assign pix_read_valid  = !mig_rd_empty;
  assign w_pop           = pix_read_valid && pix_read_ready;
  assign mig_rd_en       = w_pop;

  assign pix_write_ready = r_busy && !mig_wr_full &&
                           (((FW_W+1)'(r_wr_issued) + (FW_W+1)'(r_wr_staged)) <
                            (FW_W+1)'(r_frame_words));
  assign w_push          = pix_write_valid && pix_write_ready;
  assign mig_wr_en       = w_push;
  assign mig_wr_data     = pix_write;
  assign mig_wr_mask     = '0;

  assign w_cmd_len  = FW_W'(r_cmd_bl) + FW_W'(1);
  assign w_issue_rd = (r_state == CMD) && (r_cmd_instr == MIG_CMD_RD);
  assign w_issue_wr = (r_state == CMD) && (r_cmd_instr != MIG_CMD_RD);

  // Issue and push/pop in the same cycle combine arithmetically
  always_comb begin
    w_outst_nxt  = r_rd_outstanding;
    w_underflow  = 1'b0;
    w_staged_nxt = r_wr_staged;
    if (w_issue_rd) w_outst_nxt = r_rd_outstanding + OUTST_W'(w_cmd_len);
    if (w_pop) begin
      if (w_outst_nxt == '0) w_underflow = 1'b1;
      else                   w_outst_nxt = w_outst_nxt - OUTST_W'(1);
    end
    if (w_push)     w_staged_nxt = w_staged_nxt + FW_W'(1);
    if (w_issue_wr) w_staged_nxt = w_staged_nxt - w_cmd_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_last_grant     <= GRANT_WR;
      r_frame_words    <= '0;
      r_rd_issued      <= '0;
      r_wr_issued      <= '0;
      r_wr_staged      <= '0;
      r_rd_outstanding <= '0;
      r_busy           <= 1'b0;
      r_error          <= 1'b0;
      r_cmd_en         <= 1'b0;
      r_cmd_instr      <= MIG_CMD_WR;
      r_cmd_bl         <= '0;
      r_cmd_addr       <= '0;
    end else begin
      r_rd_outstanding <= w_outst_nxt;
      r_wr_staged      <= w_staged_nxt;
      r_cmd_en         <= 1'b0;
      if (mig_rd_overflow || mig_wr_underrun || w_underflow || (vsync && r_busy))
        r_error <= 1'b1;

      case (r_state)
        IDLE: begin
          if (vsync && enable && (frame_bytes[23:4] != '0)) begin
            r_frame_words    <= frame_bytes[23:4];
            r_rd_issued      <= '0;
            r_wr_issued      <= '0;
            r_wr_staged      <= '0;
            r_rd_outstanding <= '0;
            r_busy           <= 1'b1;
            r_state          <= ARB;
          end
        end
        ARB: begin
          if (!enable) begin
            // Staged words that never got a write command are lost
            if (r_wr_staged != '0) r_error <= 1'b1;
            r_state <= DRAIN;
          end else if ((r_rd_issued == r_frame_words) && (r_wr_issued == r_frame_words)) begin
            r_state <= DRAIN;
          end else if (!mig_cmd_full && w_grant_any) begin
            r_cmd_en <= 1'b1;
            r_state  <= CMD;
            if (w_grant_rd) begin
              r_cmd_instr <= MIG_CMD_RD;
              r_cmd_bl    <= 6'(w_rd_len - FW_W'(1));
              r_cmd_addr  <= BASE_ADDR + 30'({r_rd_issued, 4'b0000});
            end else begin
              r_cmd_instr <= MIG_CMD_WR;
              r_cmd_bl    <= 6'(w_wr_len - FW_W'(1));
              r_cmd_addr  <= BASE_ADDR + 30'({r_wr_issued, 4'b0000});
            end
          end
        end
        CMD: begin
          if (r_cmd_instr == MIG_CMD_RD) begin
            r_rd_issued  <= r_rd_issued + w_cmd_len;
            r_last_grant <= GRANT_RD;
          end else begin
            r_wr_issued  <= r_wr_issued + w_cmd_len;
            r_last_grant <= GRANT_WR;
          end
          r_state <= ARB;
        end
        DRAIN: begin
          if (r_rd_outstanding == '0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mig_cmd_en        = r_cmd_en;
  assign mig_cmd_instr     = r_cmd_instr;
  assign mig_cmd_bl        = r_cmd_bl;
  assign mig_cmd_byte_addr = r_cmd_addr;
  assign busy              = r_busy;
  assign error             = r_error;

endmodule
